bcd_to_bin_conv: RTL and testbench

Sequential BCD-to-binary decoder for packed BCD values in the counter datapath, such as BCD count values and BCD modulus settings. It undoes the BCD encoding produced by the counter so that downstream logic can compare or do arithmetic in plain binary. It converts one digit per clock, most-significant digit first, using Horner accumulation (acc = acc*10 + digit). It uses a start/busy/done handshake and flags illegal BCD digits.

---
 rtl/bcd_to_bin_conv.sv | 125 ++++++++++++
 tb/tb_bcd_to_bin_conv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_conv.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first, Horner accumulation.
// Optional build macro BCD2BIN_CLAMP_EN: illegal digits (>9) are clamped to 9 before accumulation.
module bcd_to_bin_conv #(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_WIDTH-1:0]  bin_out,
  output logic                  bcd_err,
  output logic                  dbg_state_o
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  // Handshake: start is sampled only in S_IDLE; busy is high for exactly DIGITS
  // cycles; done pulses for one cycle and bin_out/bcd_err hold until the next done.

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   shift_q, shift_d;
  logic [BIN_WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic                  bcd_err_q, bcd_err_d;

  logic [3:0]            digit;
  logic                  digit_bad;
  logic [3:0]            digit_eff;
  logic [BIN_WIDTH-1:0]  acc_next;

  assign digit     = shift_q[4*DIGITS-1 -: 4];
  assign digit_bad = (digit > 4'd9);

`ifdef BCD2BIN_CLAMP_EN
  assign digit_eff = digit_bad ? 4'd9 : digit;
`else
  assign digit_eff = digit;
`endif

  // Low BIN_WIDTH bits of acc*10+d do not depend on the dropped high bits, so
  // computing directly at BIN_WIDTH gives the same modulo-2^BIN_WIDTH wrap.
  assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_WIDTH'(digit_eff);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_d     = bin_q;
    bcd_err_d = bcd_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        acc_d   = acc_next;
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + CW'(1);
        err_d   = err_q | digit_bad;
        if (cnt_q == LAST_DIGIT) begin
          bin_d     = acc_next;
          bcd_err_d = err_q | digit_bad;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_q     <= bin_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bin_out     = bin_q;
  assign bcd_err     = bcd_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Directed bench for bcd_to_bin_conv (DIGITS=3, BIN_WIDTH=10); expected values hand-computed.
module tb_bcd_to_bin_conv;

  localparam int DIGITS    = 3;
  localparam int BIN_WIDTH = 10;

  logic                 sys_clk;
  logic                 sys_rst_n;
  logic                 start;
  logic [4*DIGITS-1:0]  bcd_in;
  logic                 busy;
  logic                 done;
  logic [BIN_WIDTH-1:0] bin_out;
  logic                 bcd_err;
  logic                 dbg_state_o;

  int checks   = 0;
  int failures = 0;

  bcd_to_bin_conv #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .bcd_in      (bcd_in),
    .busy        (busy),
    .done        (done),
    .bin_out     (bin_out),
    .bcd_err     (bcd_err),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a conversion and wait (bounded) for done; checks latency and result.
  task automatic run_conv(input string tag, input logic [11:0] v,
                          input int exp_bin, input int exp_err);
    int n;
    bit seen;
    start  = 1'b1;
    bcd_in = v;
    step();
    chk({tag, "_busy_on_accept"}, int'(busy), 1);
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      step();
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, DIGITS);
    chk({tag, "_bin"}, int'(bin_out), exp_bin);
    chk({tag, "_err"}, int'(bcd_err), exp_err);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    step();
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_bin_held"}, int'(bin_out), exp_bin);
  endtask

  initial begin
    int dcount;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    bcd_in    = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(bcd_err), 0);
    chk("rst_state", int'(dbg_state_o), 0);
    step();
    sys_rst_n = 1'b1;
    step();
    chk("idle_no_done", int'(done), 0);

    // 1: 149 with explicit cycle-by-cycle handshake
    start  = 1'b1;
    bcd_in = 12'h149;
    step();
    chk("t1_busy_c0", int'(busy), 1);
    chk("t1_state_conv", int'(dbg_state_o), 1);
    start = 1'b0;
    step();
    chk("t1_busy_c1", int'(busy), 1);
    chk("t1_done_c1", int'(done), 0);
    step();
    chk("t1_busy_c2", int'(busy), 1);
    chk("t1_done_c2", int'(done), 0);
    step();
    chk("t1_done", int'(done), 1);
    chk("t1_busy_off", int'(busy), 0);
    chk("t1_bin", int'(bin_out), 149);
    chk("t1_err", int'(bcd_err), 0);
    step();
    chk("t1_done_low", int'(done), 0);
    chk("t1_bin_held", int'(bin_out), 149);

    // 2: 023 then 999 back-to-back, start high in the done cycle
    start  = 1'b1;
    bcd_in = 12'h023;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("t2a_done", int'(done), 1);
    chk("t2a_bin", int'(bin_out), 23);
    start  = 1'b1;
    bcd_in = 12'h999;
    step();
    chk("t2b_accept_busy", int'(busy), 1);
    chk("t2b_done_low", int'(done), 0);
    start = 1'b0;
    step();
    step();
    chk("t2b_not_yet", int'(done), 0);
    step();
    chk("t2b_done_4_apart", int'(done), 1);
    chk("t2b_bin", int'(bin_out), 999);
    chk("t2b_err", int'(bcd_err), 0);
    step();

    // 3: illegal digit A
`ifdef BCD2BIN_CLAMP_EN
    run_conv("t3_0a5", 12'h0A5, 95, 1);
`else
    run_conv("t3_0a5", 12'h0A5, 105, 1);
`endif
    // error flag must clear on the next conversion
    run_conv("t3_clear", 12'h042, 42, 0);

    // 4: start during busy is ignored, bcd_in changes have no effect
    start  = 1'b1;
    bcd_in = 12'h150;
    step();
    start = 1'b0;
    step();
    start  = 1'b1;
    bcd_in = 12'h024;
    step();
    start  = 1'b0;
    bcd_in = 12'h888;
    step();
    chk("t4_done", int'(done), 1);
    chk("t4_bin", int'(bin_out), 150);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dcount++;
    end
    chk("t4_single_done", dcount, 0);
    chk("t4_idle", int'(busy), 0);

    // 5: reset mid-conversion
    start  = 1'b1;
    bcd_in = 12'h777;
    step();
    start = 1'b0;
    step();
    step();
    sys_rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", int'(busy), 0);
    chk("t5_done_rst", int'(done), 0);
    chk("t5_bin_rst", int'(bin_out), 0);
    chk("t5_err_rst", int'(bcd_err), 0);
    step();
    sys_rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) dcount++;
    end
    chk("t5_no_done_after", dcount, 0);
    run_conv("t5_fresh_000", 12'h000, 0, 0);

    // 6: boundaries
    run_conv("t6_100", 12'h100, 100, 0);
    run_conv("t6_000", 12'h000, 0, 0);
    run_conv("t6_909", 12'h909, 909, 0);
`ifdef BCD2BIN_CLAMP_EN
    run_conv("t6_fff", 12'hFFF, 999, 1);
`else
    // 15*100+15*10+15 = 1665, wraps mod 1024 to 641
    run_conv("t6_fff", 12'hFFF, 641, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
